// File: rtl/axi_lite_reg_pkg.sv
// axi_lite_reg_pkg: shared response codes, read-state type and ID default for the AXI-Lite register slave
package axi_lite_reg_pkg;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [1:0]  RESP_SLVERR      = 2'b10;
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4158_4C31;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite register file, last register is a read-only ID; define AXIL_REG_SLVERR_EN for SLVERR on out-of-range accesses
module axi_lite_reg_slave
    import axi_lite_reg_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
)(
    input  logic                   s0_axi_aclk,
    input  logic                   s0_axi_areset,
    input  logic [31:0]            s0_axi_awaddr,
    input  logic [2:0]             s0_axi_awprot,
    input  logic                   s0_axi_awvalid,
    output logic                   s0_axi_awready,
    input  logic [31:0]            s0_axi_wdata,
    input  logic [3:0]             s0_axi_wstrb,
    input  logic                   s0_axi_wvalid,
    output logic                   s0_axi_wready,
    output logic [1:0]             s0_axi_bresp,
    output logic                   s0_axi_bvalid,
    input  logic                   s0_axi_bready,
    input  logic [31:0]            s0_axi_araddr,
    input  logic [2:0]             s0_axi_arprot,
    input  logic                   s0_axi_arvalid,
    output logic                   s0_axi_arready,
    output logic [31:0]            s0_axi_rdata,
    output logic [1:0]             s0_axi_rresp,
    output logic                   s0_axi_rvalid,
    input  logic                   s0_axi_rready,
    output logic [32*NUM_REGS-1:0] reg_q
);
    localparam int IW = $clog2(NUM_REGS);
    localparam logic [IW-1:0] ID_IDX = IW'(NUM_REGS - 1);
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    logic [31:0]   r_regs [NUM_REGS];
    logic          r_aw_held, r_w_held, r_bvalid;
    logic [31:0]   r_awaddr, r_wdata;
    logic [3:0]    r_wstrb;
    logic [1:0]    r_bresp, r_rresp;
    logic [31:0]   r_rdata;
    rstate_t       r_rstate, w_rstate_next;
    logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_win, w_rin, w_unused;
    logic [IW-1:0] w_widx, w_ridx;
    logic [31:0]   w_rd_val;
    logic [1:0]    w_rd_resp;

    assign s0_axi_awready = !r_aw_held && !r_bvalid;
    assign s0_axi_wready  = !r_w_held && !r_bvalid;
    assign s0_axi_bvalid  = r_bvalid;
    assign s0_axi_bresp   = r_bresp;
    assign s0_axi_arready = r_rstate == R_IDLE;
    assign s0_axi_rvalid  = r_rstate == R_DATA;
    assign s0_axi_rdata   = r_rdata;
    assign s0_axi_rresp   = r_rresp;

    assign w_aw_hs  = s0_axi_awvalid && s0_axi_awready;
    assign w_w_hs   = s0_axi_wvalid && s0_axi_wready;
    assign w_ar_hs  = s0_axi_arvalid && s0_axi_arready;
    assign w_commit = r_aw_held && r_w_held;
    assign w_widx   = r_awaddr[IW+1:2];
    assign w_ridx   = s0_axi_araddr[IW+1:2];
    assign w_win    = r_awaddr[31:IW+2] == '0;
    assign w_rin    = s0_axi_araddr[31:IW+2] == '0;
    assign w_unused = ^{s0_axi_awprot, s0_axi_arprot, r_awaddr[1:0], s0_axi_araddr[1:0]};

    // The ID slot is a constant; storage behind it is never written
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[32*i +: 32] = (i == NUM_REGS - 1) ? ID_VALUE : r_regs[i];
    end

    // Write channel: hold AW and W independently, commit once both are held, then wait for B
    always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
        if (s0_axi_areset) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s0_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s0_axi_wdata;
                r_wstrb  <= s0_axi_wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_win ? RESP_OKAY : OOR_RESP;
                if (w_win && w_widx != ID_IDX)
                    for (int b = 0; b < 4; b++)
                        if (r_wstrb[b]) r_regs[w_widx][8*b +: 8] <= r_wdata[8*b +: 8];
            end else if (r_bvalid && s0_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read lookup from the pre-edge register contents, so a same-edge write is not visible
    always_comb begin
        w_rd_val  = !w_rin ? 32'h0 : (w_ridx == ID_IDX ? ID_VALUE : r_regs[w_ridx]);
        w_rd_resp = w_rin ? RESP_OKAY : OOR_RESP;
    end

    // Read state register; data and response are captured on the AR handshake
    always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
        if (s0_axi_areset) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_ar_hs) begin
                r_rdata <= w_rd_val;
                r_rresp <= w_rd_resp;
            end
        end
    end

    // Read next-state: accept an address when idle, return once the data is taken
    always_comb begin
        w_rstate_next = r_rstate;
        if (r_rstate == R_IDLE)
            w_rstate_next = s0_axi_arvalid ? R_DATA : R_IDLE;
        else
            w_rstate_next = s0_axi_rready ? R_IDLE : R_DATA;
    end
endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, giving the number of 32-bit registers (power of 2, 2..16).
REQ-002 SHALL have parameter ID_VALUE, default 32'h4158_4C31, giving the read-only value of the last register.
REQ-003 SHALL have the following ports:
- s0_axi_aclk  in  1  single clock; all logic on the rising edge.
- s0_axi_areset  in  1  reset, asynchronous, active-high.
- s0_axi_awaddr  in  32  write address.
- s0_axi_awprot  in  3  ignored.
- s0_axi_awvalid / s0_axi_awready  in / out  1  write-address handshake.
- s0_axi_wdata  in  32  write data.
- s0_axi_wstrb  in  4  byte enables.
- s0_axi_wvalid / s0_axi_wready  in / out  1  write-data handshake.
- s0_axi_bresp  out  2  write response.
- s0_axi_bvalid / s0_axi_bready  out / in  1  write-response handshake.
- s0_axi_araddr  in  32  read address.
- s0_axi_arprot  in  3  ignored.
- s0_axi_arvalid / s0_axi_arready  in / out  1  read-address handshake.
- s0_axi_rdata  out  32  read data.
- s0_axi_rresp  out  2  read response.
- s0_axi_rvalid / s0_axi_rready  out / in  1  read-data handshake.
- reg_q  out  32*NUM_REGS  flat register contents; register i at bits [32i+31:32i].

Function
REQ-004 SHALL decode register index from addr[$clog2(NUM_REGS)+1:2]; addr[1:0] SHALL be ignored; an address SHALL be in range when addr < 4*NUM_REGS.
REQ-005 SHALL accept AW and W independently, in either order or in the same cycle, capturing each into a holding register on its handshake.
REQ-006 SHALL drive awready = !aw_held && !bvalid and wready = !w_held && !bvalid.
REQ-007 SHALL commit the write on the first rising edge where both aw_held and w_held are set: byte lanes with wstrb=1 update, others keep their value; both held flags clear; bvalid rises on the same edge.
REQ-008 With AW and W both accepted at edge N, the register SHALL update and bvalid SHALL be high at edge N+1.
REQ-009 SHALL hold bvalid and bresp stable until bready is high at a rising edge, then deassert bvalid; no new AW/W SHALL be accepted while bvalid is high.
REQ-010 The read side SHALL use states R_IDLE (arready=1) and R_DATA (rvalid=1, arready=0).
REQ-011 On the AR handshake in R_IDLE, rdata and rresp SHALL be registered and the state SHALL go to R_DATA on the same edge, giving rvalid one cycle after the handshake.
REQ-012 In R_DATA, rdata, rresp and rvalid SHALL hold until rready is high at an edge, then the state SHALL return to R_IDLE.
REQ-013 A read and a write to the same register committing on the same edge SHALL return the pre-write value.
REQ-014 Register NUM_REGS-1 SHALL always read ID_VALUE; writes to it SHALL be dropped with OKAY.
REQ-015 Out-of-range writes SHALL be dropped; out-of-range reads SHALL return 32'h0.
REQ-016 The in-range response SHALL be OKAY (2'b00).

Reset
REQ-017 While s0_axi_areset is high: all registers except the ID register = 0, held flags = 0, read state = R_IDLE; bvalid, rvalid, bresp, rresp, rdata = 0.
REQ-018 Reset mid-transaction SHALL abandon any held AW/W, pending B or pending R; awready, wready and arready SHALL be 1 on the first edge after release.

Configuration
REQ-019 With AXIL_REG_SLVERR_EN defined, out-of-range accesses SHALL respond SLVERR (2'b10) on bresp/rresp.
REQ-020 Without AXIL_REG_SLVERR_EN, out-of-range accesses SHALL respond OKAY; REQ-015 applies in both cases.

Structure
REQ-021 Package axi_lite_reg_pkg SHALL hold the response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10), the read-state enum typedef and the ID_VALUE default.
REQ-022 The block SHALL be a single module with no sub-modules.

Verification
REQ-023 Write 0x0000_0004 data 0xDEADBEEF strb 0xF, then read 0x4 -> bresp=0, rdata=0xDEADBEEF, rresp=0.
REQ-024 W presented 3 cycles before AW (addr 0x8, data 0x1234_5678) -> wready drops after the W handshake, bvalid one cycle after the AW handshake, reg_q[95:64]=0x1234_5678.
REQ-025 Write addr 0x0 data 0xAABBCCDD strb 0x5 over 0 -> register = 0x00BB00DD.
REQ-026 bready held low 5 cycles after bvalid -> bvalid stays high, awready=wready=0, next write accepted only after the B handshake.
REQ-027 Read addr 0x40 -> rdata=0; rresp=2 with AXIL_REG_SLVERR_EN, rresp=0 without; read addr 0x1C -> 0x4158_4C31.
REQ-028 Assert reset while bvalid=1 after writing 0xFF to reg 1 -> bvalid=0, reg_q all zero except ID, awready=1 after release.
